fifo_wr_arbiter: RTL and testbench

- Shares the write port of one `fifo` instance among NUM_REQ producers using round-robin arbitration with burst locking.
- Each producer uses a valid/ready handshake; the arbiter issues registered `fifo_wr_en`/`fifo_wr_data`.
- Throttles on the FIFO's `full`/`almost_full` flags so no write is ever issued into a full FIFO and no data is lost.
- Sits directly in front of the FIFO write side.

---
 rtl/fifo_wr_arbiter.sv | 109 ++++++++++
 tb/tb_fifo_wr_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ valid/ready producers, with burst locking.
// Accepted beat is written one cycle later; accepts stall whenever full/almost_full leaves no room.
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic                       fifo_full,
  input  logic                       fifo_almost_full,
  output logic                       fifo_wr_en,
  output logic [WIDTH-1:0]           fifo_wr_data,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy
);
  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(MAX_BURST + 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] LOCK = 1'b1;

  logic [0:0]     state;
  logic [IDW-1:0] last_grant;
  logic [IDW-1:0] winner;
  logic [IDW-1:0] cand;
  logic [IDW-1:0] sel;
  logic [CW-1:0]  beat_cnt;
  logic           space;
  logic           found;
  logic           accept;
  int             idx;

  // A write already in flight will consume the last slot when almost_full is up.
  assign space = !fifo_full && !(fifo_almost_full && fifo_wr_en);

  always_comb begin
    winner = last_grant;
    found  = 1'b0;
    idx    = 0;
    cand   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(last_grant) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = IDW'(idx);
      if (!found && req_valid[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  assign sel = (state == LOCK) ? grant_id : winner;

  // rst_n is active-high: ready is held off while reset is asserted.
  always_comb begin
    req_ready = '0;
    if (!rst_n && space) begin
      if (state == LOCK)
        req_ready[grant_id] = req_valid[grant_id];
      else if (found)
        req_ready[winner] = 1'b1;
    end
  end

  assign accept = |req_ready;
  assign busy   = (state == LOCK);

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state        <= IDLE;
      fifo_wr_en   <= 1'b0;
      fifo_wr_data <= '0;
      grant_id     <= '0;
      last_grant   <= IDW'(NUM_REQ - 1);
      beat_cnt     <= '0;
    end else begin
      fifo_wr_en <= accept;
      if (accept)
        fifo_wr_data <= req_data[int'(sel)*WIDTH +: WIDTH];

      case (state)
        IDLE: begin
          if (accept) begin
            grant_id   <= winner;
            last_grant <= winner;
            beat_cnt   <= CW'(1);
            state      <= (req_last[winner] || MAX_BURST == 1) ? IDLE : LOCK;
          end
        end
        default: begin
          if (!req_valid[grant_id]) begin
            state <= IDLE;
          end else if (accept) begin
            if (beat_cnt != CW'(MAX_BURST))
              beat_cnt <= beat_cnt + CW'(1);
            if (req_last[grant_id] || (int'(beat_cnt) + 1 >= MAX_BURST))
              state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios then random traffic, all checked against a cycle model.
module tb_fifo_wr_arbiter;
  localparam int N = 4, W = 8, MB = 4, DEPTH = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] req_valid, req_last, req_ready;
  logic [N*W-1:0] req_data;
  logic         fifo_full, fifo_almost_full, fifo_wr_en, busy;
  logic [W-1:0] fifo_wr_data;
  logic [1:0]   grant_id;

  logic flag_ovr, ovr_full, ovr_af, fifo_rd;
  int   fcnt;
  int   compared = 0, mismatched = 0;
  int   seq [N];
  int   t3_seq [9] = '{1, 1, 1, 1, 3, 3, 3, 3, 1};
  int   base;

  bit           m_locked, m_wr_en;
  int           m_grant, m_last, m_cnt;
  logic [W-1:0] m_wr_data;

  logic [N-1:0] obs_rdy;
  logic         obs_wen, obs_busy;
  logic [W-1:0] obs_wdat;
  logic [1:0]   obs_gid;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.NUM_REQ(N), .WIDTH(W), .MAX_BURST(MB)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .fifo_full(fifo_full),
    .fifo_almost_full(fifo_almost_full), .fifo_wr_en(fifo_wr_en),
    .fifo_wr_data(fifo_wr_data), .grant_id(grant_id), .busy(busy)
  );

  // Occupancy of the FIFO behind the arbiter.
  assign fifo_full        = flag_ovr ? ovr_full : (fcnt >= DEPTH);
  assign fifo_almost_full = flag_ovr ? ovr_af   : (fcnt == DEPTH - 1);

  always @(posedge clk or posedge rst_n)
    if (rst_n) fcnt <= 0;
    else fcnt <= fcnt + (fifo_wr_en ? 1 : 0) - ((fifo_rd && fcnt > 0) ? 1 : 0);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_locked = 0; m_wr_en = 0; m_wr_data = '0;
    m_grant = 0; m_last = N - 1; m_cnt = 0;
  endtask

  task automatic drive_data();
    for (int i = 0; i < N; i++) req_data[i*W +: W] = W'(i*64 + seq[i] % 64);
  endtask

  task automatic do_reset();
    rst_n = 1'b1; req_valid = '0; req_last = '0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    model_reset();
  endtask

  // One clock: predict from the rules, compare at negedge, advance the model.
  task automatic step();
    logic [N-1:0] er;
    bit sp, acc;
    int w, idx;
    @(negedge clk);
    sp = !fifo_full && !(fifo_almost_full && m_wr_en);
    er = '0; idx = 0;
    if (!m_locked) begin
      if (sp) for (int k = 1; k <= N; k++) begin
        w = (m_last + k) % N;
        if (er == '0 && req_valid[w]) er[w] = 1'b1;
      end
    end else if (req_valid[m_grant] && sp) begin
      er[m_grant] = 1'b1;
    end
    obs_rdy = req_ready; obs_wen = fifo_wr_en; obs_wdat = fifo_wr_data;
    obs_busy = busy; obs_gid = grant_id;
    chk("ready", 32'(req_ready), 32'(er));
    chk("wr_en", 32'(fifo_wr_en), 32'(m_wr_en));
    chk("wr_data", 32'(fifo_wr_data), 32'(m_wr_data));
    chk("busy", 32'(busy), 32'(m_locked));
    chk("grant_id", 32'(grant_id), 32'(m_grant));
    if (!flag_ovr) chk("wr_while_full", 32'(fifo_wr_en & fifo_full), 32'h0);
    acc = (er != '0);
    for (int i = 0; i < N; i++) if (er[i]) idx = i;
    m_wr_en = acc;
    if (acc) m_wr_data = req_data[idx*W +: W];
    if (!m_locked) begin
      if (acc) begin
        m_grant = idx; m_last = idx; m_cnt = 1;
        m_locked = !req_last[idx] && (MB > 1);
      end
    end else if (!req_valid[m_grant]) begin
      m_locked = 0;
    end else if (acc) begin
      m_cnt++;
      if (req_last[idx] || m_cnt >= MB) m_locked = 0;
    end
    @(posedge clk); #1;
    if (acc) begin seq[idx]++; drive_data(); end
  endtask

  initial begin
    rst_n = 1'b1; req_valid = '0; req_last = '0;
    flag_ovr = 0; ovr_full = 0; ovr_af = 0; fifo_rd = 1;
    for (int i = 0; i < N; i++) seq[i] = 0;
    drive_data(); model_reset();
    #12;
    req_valid = '1;
    #1;
    chk("rst_wr_en", 32'(fifo_wr_en), 32'h0);
    chk("rst_wr_data", 32'(fifo_wr_data), 32'h0);
    chk("rst_grant", 32'(grant_id), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_ready", 32'(req_ready), 32'h0);
    req_valid = '0;
    @(posedge clk); #1;
    rst_n = 1'b0;

    // Single requester, 3-beat burst.
    for (int b = 0; b < 3; b++) begin
      req_valid = 4'b0100; req_last = (b == 2) ? 4'b0100 : 4'b0000;
      step();
      chk("t1_ready", 32'(obs_rdy), 32'h4);
      chk("t1_busy", 32'(obs_busy), 32'(b > 0));
      if (b > 0) chk("t1_data", 32'(obs_wdat), 32'(8'h80 + b - 1));
    end
    req_valid = '0; req_last = '0;
    step();
    chk("t1_data_last", 32'(obs_wdat), 32'h82);
    chk("t1_wen_last", 32'(obs_wen), 32'h1);
    chk("t1_busy_end", 32'(obs_busy), 32'h0);
    chk("t1_grant", 32'(obs_gid), 32'h2);

    // All valid, single-beat bursts: strict rotation.
    do_reset();
    req_valid = '1; req_last = '1;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("t2_order", 32'(obs_rdy), 32'(1 << (k % 4)));
      chk("t2_onehot", 32'($countones(obs_rdy)), 32'h1);
    end

    // Burst cap then hand-over.
    do_reset();
    req_valid = 4'b1010; req_last = '0;
    for (int k = 0; k < 9; k++) begin
      step();
      chk("t3_grant", 32'(obs_rdy), 32'(1 << t3_seq[k]));
    end

    // Flag throttling mid-burst.
    do_reset();
    flag_ovr = 1; base = seq[0];
    req_valid = 4'b0001; req_last = '0;
    step();
    chk("t4_first", 32'(obs_rdy), 32'h1);
    ovr_af = 1;
    step();
    chk("t4_af_ready", 32'(obs_rdy), 32'h0);
    chk("t4_af_wen", 32'(obs_wen), 32'h1);
    ovr_af = 0; ovr_full = 1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t4_full_ready", 32'(obs_rdy), 32'h0);
      chk("t4_full_wen", 32'(obs_wen), 32'h0);
      chk("t4_full_busy", 32'(obs_busy), 32'h1);
    end
    ovr_full = 0;
    for (int j = 0; j < 3; j++) begin
      step();
      chk("t4_resume_ready", 32'(obs_rdy), 32'h1);
      chk("t4_resume_data", 32'(obs_wdat), 32'(W'(base + j)));
    end
    req_valid = '0;
    step();
    chk("t4_final_data", 32'(obs_wdat), 32'(W'(base + 3)));
    chk("t4_final_busy", 32'(obs_busy), 32'h0);
    flag_ovr = 0;

    // Reset in the middle of a burst.
    do_reset();
    req_valid = 4'b0001; req_last = '0;
    step();
    req_valid = 4'b0011;
    #2; rst_n = 1'b1; #1;
    chk("t5_wen", 32'(fifo_wr_en), 32'h0);
    chk("t5_busy", 32'(busy), 32'h0);
    chk("t5_ready", 32'(req_ready), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b0; model_reset();
    step();
    chk("t5_prio", 32'(obs_rdy), 32'h1);
    chk("t5_idle", 32'(obs_busy), 32'h0);

    // Grantee drops valid while locked.
    do_reset();
    req_valid = 4'b0100;
    step();
    chk("t6_grant", 32'(obs_rdy), 32'h4);
    req_valid = 4'b0101;
    step();
    chk("t6_locked", 32'(obs_rdy), 32'h4);
    chk("t6_busy", 32'(obs_busy), 32'h1);
    req_valid = 4'b0001;
    step();
    chk("t6_drop", 32'(obs_rdy), 32'h0);
    chk("t6_drop_busy", 32'(obs_busy), 32'h1);
    step();
    chk("t6_req0", 32'(obs_rdy), 32'h1);
    chk("t6_idle", 32'(obs_busy), 32'h0);

    // Random traffic with a draining FIFO.
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      req_valid = N'($urandom);
      req_last  = N'($urandom) & N'($urandom);
      fifo_rd   = ($urandom % 3 == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
